useq: RTL and testbench



---
 rtl/useq.sv | 180 ++++++++++++++++++
 tb/tb_useq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq.sv
// useq: parametrised microcode sequencer.
// Produces the next micro-address from the current microinstruction's sequencing fields.
// Features: a call/return stack, hold and wait handshakes, and opcode dispatch with an
// interrupt hook.
// Optional loop counter: define USEQ_LOOP_EN to enable op 7 LOOP; otherwise op 7 acts as NEXT.
module useq #(
    parameter int unsigned AW      = 10,
    parameter int unsigned CW      = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RST_VEC = 0,
    parameter int unsigned IRQ_VEC = 1,
    parameter int unsigned LCW     = 8,
    localparam int unsigned SPW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             hold,
    input  logic [2:0]       seq_op,
    input  logic [AW-1:0]    seq_target,
    input  logic [CW-1:0]    cond_sel,
    input  logic             cond_inv,
    input  logic [2**CW-1:0] cond,
    input  logic [AW-1:0]    disp_addr,
    input  logic             disp_valid,
    input  logic             irq_req,
    output logic             irq_ack,
    output logic [AW-1:0]    uaddr,
    output logic             disp_req,
    output logic [SPW-1:0]   sp_depth,
    output logic             err_ovf,
    output logic             err_unf,
    input  logic             cnt_load,
    input  logic [LCW-1:0]   cnt_val
);

    // Stack index width; the array is rounded up to a power of two so any index is legal.
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OpNext     = 3'd0,
        OpJump     = 3'd1,
        OpBranch   = 3'd2,
        OpDispatch = 3'd3,
        OpCall     = 3'd4,
        OpRet      = 3'd5,
        OpWait     = 3'd6,
        OpLoop     = 3'd7
    } op_e;

    op_e           op;
    logic          c;
    logic [AW-1:0] inc;
    logic [AW-1:0] uaddr_q, uaddr_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ack_q, ack_d;
    logic          push;
    logic [IW-1:0] push_idx, top_idx;
    logic [AW-1:0] stack_q [2**IW];

`ifdef USEQ_LOOP_EN
    logic [LCW-1:0] cnt_q, cnt_d;
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_load, cnt_val};
`endif

    assign op       = op_e'(seq_op);
    assign c        = cond[cond_sel] ^ cond_inv;
    assign inc      = uaddr_q + AW'(1);
    assign push_idx = IW'(sp_q);
    assign top_idx  = IW'(sp_q - SPW'(1));

    assign uaddr    = uaddr_q;
    assign sp_depth = sp_q;
    assign err_ovf  = ovf_q;
    assign err_unf  = unf_q;
    assign irq_ack  = ack_q;
    // Combinational: asserted whenever the current op is DISPATCH.
    assign disp_req = (op == OpDispatch);

    // Next-state decode of the sequencing op.
    always_comb begin
        uaddr_d = uaddr_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ack_d   = 1'b0;
        push    = 1'b0;
`ifdef USEQ_LOOP_EN
        cnt_d   = cnt_q;
`endif
        unique case (op)
            OpNext:   uaddr_d = inc;
            OpJump:   uaddr_d = seq_target;
            OpBranch: uaddr_d = c ? seq_target : inc;
            OpDispatch: begin
                // The interrupt hook takes precedence over the dispatch ROM.
                if (irq_req) begin
                    uaddr_d = AW'(IRQ_VEC);
                    ack_d   = 1'b1;
                end else if (disp_valid) begin
                    uaddr_d = disp_addr;
                end
            end
            OpCall: begin
                // The jump is taken even when the push is dropped.
                uaddr_d = seq_target;
                if (sp_q == SPW'(DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SPW'(1);
                end
            end
            OpRet: begin
                if (sp_q == '0) begin
                    uaddr_d = AW'(RST_VEC);
                    unf_d   = 1'b1;
                end else begin
                    uaddr_d = stack_q[top_idx];
                    sp_d    = sp_q - SPW'(1);
                end
            end
            OpWait: uaddr_d = c ? inc : uaddr_q;
            OpLoop: begin
`ifdef USEQ_LOOP_EN
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - LCW'(1);
                    uaddr_d = seq_target;
                end else begin
                    uaddr_d = inc;
                end
`else
                uaddr_d = inc;
`endif
            end
        endcase
`ifdef USEQ_LOOP_EN
        // The load overrides any decrement; the LOOP decision above used the old count.
        if (cnt_load) begin
            cnt_d = cnt_val;
        end
`endif
    end

    // Sequencer state; hold freezes everything and suppresses irq_ack.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            uaddr_q <= AW'(RST_VEC);
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ack_q   <= 1'b0;
`ifdef USEQ_LOOP_EN
            cnt_q   <= '0;
`endif
        end else if (hold) begin
            ack_q   <= 1'b0;
        end else begin
            uaddr_q <= uaddr_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ack_q   <= ack_d;
`ifdef USEQ_LOOP_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Return-address storage; entries need no reset because sp_depth guards them.
    always_ff @(posedge clk) begin
        if (n_reset && !hold && push) begin
            stack_q[push_idx] <= inc;
        end
    end

endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq with a queue-based reference model.
// Covers directed plan scenarios, followed by a randomized phase.
// Define USEQ_LOOP_EN for both the bench and the RTL to exercise the loop counter.
module tb_useq;

    localparam int unsigned AW      = 10;
    localparam int unsigned CW      = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned RST_VEC = 0;
    localparam int unsigned IRQ_VEC = 1;
    localparam int unsigned LCW     = 8;
    localparam int unsigned SPW     = $clog2(DEPTH + 1);

    logic             clk;
    logic             n_reset;
    logic             hold;
    logic [2:0]       seq_op;
    logic [AW-1:0]    seq_target;
    logic [CW-1:0]    cond_sel;
    logic             cond_inv;
    logic [2**CW-1:0] cond;
    logic [AW-1:0]    disp_addr;
    logic             disp_valid;
    logic             irq_req;
    logic             irq_ack;
    logic [AW-1:0]    uaddr;
    logic             disp_req;
    logic [SPW-1:0]   sp_depth;
    logic             err_ovf;
    logic             err_unf;
    logic             cnt_load;
    logic [LCW-1:0]   cnt_val;

    useq #(
        .AW(AW), .CW(CW), .DEPTH(DEPTH), .RST_VEC(RST_VEC), .IRQ_VEC(IRQ_VEC), .LCW(LCW)
    ) dut (
        .clk(clk), .n_reset(n_reset), .hold(hold), .seq_op(seq_op), .seq_target(seq_target),
        .cond_sel(cond_sel), .cond_inv(cond_inv), .cond(cond), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .irq_req(irq_req), .irq_ack(irq_ack), .uaddr(uaddr),
        .disp_req(disp_req), .sp_depth(sp_depth), .err_ovf(err_ovf), .err_unf(err_unf),
        .cnt_load(cnt_load), .cnt_val(cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and a queue as the return stack.
    int unsigned m_uaddr;
    int unsigned m_stack[$];
    bit          m_ovf, m_unf, m_ack, m_valid;
    int unsigned m_cnt;
    int unsigned m_inc;
    bit          m_c;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        m_inc = (m_uaddr + 1) % (1 << AW);
        m_c   = cond[cond_sel] ^ cond_inv;
        if (!n_reset) begin
            m_uaddr = RST_VEC;
            m_stack.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_ack   = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b1;
        end else if (hold) begin
            m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            case (seq_op)
                3'd0: m_uaddr = m_inc;
                3'd1: m_uaddr = seq_target;
                3'd2: m_uaddr = m_c ? int'(seq_target) : m_inc;
                3'd3: begin
                    if (irq_req) begin
                        m_uaddr = IRQ_VEC;
                        m_ack   = 1'b1;
                    end else if (disp_valid) begin
                        m_uaddr = disp_addr;
                    end
                end
                3'd4: begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(m_inc);
                    else m_ovf = 1'b1;
                    m_uaddr = seq_target;
                end
                3'd5: begin
                    if (m_stack.size() == 0) begin
                        m_uaddr = RST_VEC;
                        m_unf   = 1'b1;
                    end else begin
                        m_uaddr = m_stack.pop_back();
                    end
                end
                3'd6: if (m_c) m_uaddr = m_inc;
                default: begin
`ifdef USEQ_LOOP_EN
                    if (m_cnt != 0) begin
                        m_cnt   = m_cnt - 1;
                        m_uaddr = seq_target;
                    end else begin
                        m_uaddr = m_inc;
                    end
`else
                    m_uaddr = m_inc;
`endif
                end
            endcase
`ifdef USEQ_LOOP_EN
            if (cnt_load) m_cnt = cnt_val;
`endif
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("uaddr", 32'(uaddr), m_uaddr);
            chk("sp_depth", 32'(sp_depth), m_stack.size());
            chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
            chk("err_unf", 32'(err_unf), 32'(m_unf));
            chk("irq_ack", 32'(irq_ack), 32'(m_ack));
            chk("disp_req", 32'(disp_req), 32'(seq_op == 3'd3));
        end
    end

    task automatic defaults();
        hold = 1'b0; seq_op = 3'd0; seq_target = '0; cond_sel = '0; cond_inv = 1'b0;
        cond = '0; disp_addr = '0; disp_valid = 1'b0; irq_req = 1'b0;
        cnt_load = 1'b0; cnt_val = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [AW-1:0] t);
        seq_op = o;
        seq_target = t;
        tick();
    endtask

    logic [AW-1:0] ret_exp [4];

    initial begin
        defaults();
        n_reset = 1'b0;
        tick();
        tick();
        chk("rst_uaddr", 32'(uaddr), 0);
        chk("rst_sp", 32'(sp_depth), 0);
        chk("rst_ovf", 32'(err_ovf), 0);
        chk("rst_unf", 32'(err_unf), 0);
        chk("rst_ack", 32'(irq_ack), 0);
        n_reset = 1'b1;

        // Plain sequencing and wrap-around.
        do_op(3'd0, '0); do_op(3'd0, '0); do_op(3'd0, '0);
        chk("next_x3", 32'(uaddr), 3);
        do_op(3'd1, 10'h3FF);
        chk("jump_3ff", 32'(uaddr), 32'h3FF);
        do_op(3'd0, '0);
        chk("wrap", 32'(uaddr), 0);

        // Branch and wait.
        cond = 8'h04; cond_sel = 3'd2;
        do_op(3'd2, 10'h080);
        chk("branch_taken", 32'(uaddr), 32'h080);
        cond_inv = 1'b1;
        do_op(3'd2, 10'h080);
        chk("branch_inv", 32'(uaddr), 32'h081);
        cond_inv = 1'b0; cond = 8'h00;
        for (int i = 0; i < 3; i++) begin
            do_op(3'd6, '0);
            chk("wait_hold", 32'(uaddr), 32'h081);
        end
        cond = 8'h04;
        do_op(3'd6, '0);
        chk("wait_go", 32'(uaddr), 32'h082);
        cond = 8'h00; cond_sel = '0;

        // Dispatch handshake.
        do_op(3'd1, 10'h010);
        seq_op = 3'd3; disp_valid = 1'b0;
        #1;
        chk("disp_req", 32'(disp_req), 1);
        tick();
        chk("disp_stall1", 32'(uaddr), 32'h010);
        tick();
        chk("disp_stall2", 32'(uaddr), 32'h010);
        disp_valid = 1'b1; disp_addr = 10'h155;
        tick();
        chk("disp_go", 32'(uaddr), 32'h155);
        chk("disp_noack", 32'(irq_ack), 0);
        disp_valid = 1'b0;
        do_op(3'd1, 10'h010);
        irq_req = 1'b1; disp_valid = 1'b1;
        do_op(3'd3, '0);
        chk("irq_vec", 32'(uaddr), IRQ_VEC);
        chk("irq_ack", 32'(irq_ack), 1);
        irq_req = 1'b0; disp_valid = 1'b0;
        do_op(3'd0, '0);
        chk("irq_ack_pulse", 32'(irq_ack), 0);
        chk("after_irq", 32'(uaddr), IRQ_VEC + 1);

        // Stack: four nested calls, overflow, four returns, underflow.
        do_op(3'd1, 10'h020);
        do_op(3'd4, 10'h040); do_op(3'd4, 10'h060); do_op(3'd4, 10'h080); do_op(3'd4, 10'h0A0);
        chk("call_sp4", 32'(sp_depth), 4);
        chk("call_noovf", 32'(err_ovf), 0);
        chk("model_sp4", m_stack.size(), 4);
        do_op(3'd4, 10'h0C0);
        chk("ovf_flag", 32'(err_ovf), 1);
        chk("ovf_sp", 32'(sp_depth), 4);
        chk("ovf_jump", 32'(uaddr), 32'h0C0);
        ret_exp[0] = 10'h081; ret_exp[1] = 10'h061; ret_exp[2] = 10'h041; ret_exp[3] = 10'h021;
        for (int i = 0; i < 4; i++) begin
            do_op(3'd5, '0);
            chk("ret_addr", 32'(uaddr), 32'(ret_exp[i]));
        end
        do_op(3'd5, '0);
        chk("unf_addr", 32'(uaddr), RST_VEC);
        chk("unf_flag", 32'(err_unf), 1);
        chk("unf_sp", 32'(sp_depth), 0);

        // Hold priority.
        do_op(3'd1, 10'h030);
        hold = 1'b1;
        do_op(3'd4, 10'h200); do_op(3'd4, 10'h200);
        chk("hold_uaddr", 32'(uaddr), 32'h030);
        chk("hold_sp", 32'(sp_depth), 0);
        hold = 1'b0;
        do_op(3'd4, 10'h200);
        chk("hold_rel_uaddr", 32'(uaddr), 32'h200);
        chk("hold_rel_sp", 32'(sp_depth), 1);
        hold = 1'b1; irq_req = 1'b1;
        do_op(3'd3, '0);
        chk("hold_irq_ack", 32'(irq_ack), 0);
        do_op(3'd3, '0);
        chk("hold_irq_uaddr", 32'(uaddr), 32'h200);
        hold = 1'b0;
        do_op(3'd3, '0);
        chk("hold_irq_go", 32'(uaddr), IRQ_VEC);
        chk("hold_irq_ack_go", 32'(irq_ack), 1);
        irq_req = 1'b0;

        // Reset mid-stall with a CALL pending.
        n_reset = 1'b0; hold = 1'b1;
        do_op(3'd4, 10'h300);
        chk("midrst_uaddr", 32'(uaddr), 0);
        chk("midrst_sp", 32'(sp_depth), 0);
        chk("midrst_ovf", 32'(err_ovf), 0);
        chk("midrst_unf", 32'(err_unf), 0);
        n_reset = 1'b1; hold = 1'b0;

        // Op 7.
`ifdef USEQ_LOOP_EN
        cnt_load = 1'b1; cnt_val = 8'd3;
        do_op(3'd1, 10'h104);
        cnt_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_op(3'd7, 10'h100);
            if (k < 3) begin
                chk("loop_jump", 32'(uaddr), 32'h100);
                for (int j = 0; j < 4; j++) do_op(3'd0, '0);
            end else begin
                chk("loop_exit", 32'(uaddr), 32'h105);
            end
        end
        // Load and LOOP together: the branch sees the old (zero) count.
        do_op(3'd1, 10'h104);
        cnt_load = 1'b1; cnt_val = 8'd2;
        do_op(3'd7, 10'h100);
        cnt_load = 1'b0;
        chk("loop_load_same", 32'(uaddr), 32'h105);
        do_op(3'd1, 10'h104);
        do_op(3'd7, 10'h100);
        chk("loop_after_load", 32'(uaddr), 32'h100);
`else
        cnt_load = 1'b1; cnt_val = 8'd3;
        do_op(3'd1, 10'h104);
        cnt_load = 1'b0;
        do_op(3'd7, 10'h100);
        chk("op7_next", 32'(uaddr), 32'h105);
`endif

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            n_reset    = ($urandom_range(0, 63) != 0);
            hold       = ($urandom_range(0, 3) == 0);
            seq_op     = 3'($urandom_range(0, 7));
            seq_target = AW'($urandom);
            cond_sel   = CW'($urandom);
            cond_inv   = 1'($urandom);
            cond       = (2**CW)'($urandom);
            disp_addr  = AW'($urandom);
            disp_valid = 1'($urandom);
            irq_req    = ($urandom_range(0, 3) == 0);
            cnt_load   = ($urandom_range(0, 7) == 0);
            cnt_val    = LCW'($urandom_range(0, 5));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
